// File: rtl/shift_reg_pkg.sv
// Shared constants and word type for the sample/coefficient history buffer.
package shift_reg_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned TAP_COUNT  = 64;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Address width for a given depth; a depth of 1 still needs a 1-bit address.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_reg_mux.sv
// Combinational size:1 read mux over the flattened tap vector; out-of-range reads return 0.
module shift_reg_mux
    import shift_reg_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH,
    parameter int unsigned size      = TAP_COUNT,
    parameter int unsigned addrWidth = addr_width(size)
) (
    input  logic [size*dataWidth-1:0] i_line,
    input  logic [addrWidth-1:0]      i_address,
    output logic [dataWidth-1:0]      o_data_c
);

    logic [dataWidth-1:0] w_tap [size];

    for (genvar g = 0; g < size; g++) begin : g_unpack
        assign w_tap[g] = i_line[g*dataWidth +: dataWidth];
    end

    // Addresses past the last tap only exist when size is not a power of two.
    always_comb begin
        o_data_c = '0;
        if (32'(i_address) < size) begin
            o_data_c = w_tap[i_address];
        end
    end

endmodule : shift_reg_mux

// File: rtl/shift_reg.sv
// Serial-in delay line of `size` words with a random-access combinational read port.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter  int unsigned dataWidth = DATA_WIDTH,
    parameter  int unsigned size      = TAP_COUNT,
    localparam int unsigned addrWidth = addr_width(size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift,
    input  logic [dataWidth-1:0] din,
    input  logic [addrWidth-1:0] address,
    output logic [dataWidth-1:0] dout
);

    // Tap i lives at bits [i*dataWidth +: dataWidth]; tap 0 holds the newest word.
    logic [size*dataWidth-1:0] r_line;
    logic [dataWidth-1:0]      w_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else if (shift) begin
            r_line <= {r_line[(size-1)*dataWidth-1:0], din};
        end
    end

    shift_reg_mux #(
        .dataWidth (dataWidth),
        .size      (size),
        .addrWidth (addrWidth)
    ) u_mux (
        .i_line    (r_line),
        .i_address (address),
        .o_data_c  (w_dout)
    );

    assign dout = w_dout;

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// Directed bench for shift_reg at default parameters (16-bit words, 64 taps).
module tb_shift_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst;
    logic          shift;
    logic [DW-1:0] din;
    logic [AW-1:0] address;
    logic [DW-1:0] dout;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] last_din;

    shift_reg dut (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .din     (din),
        .address (address),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] exp);
        checks++;
        assert (dout === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address = a;
        #1;
        check(tag, exp);
    endtask

    initial begin
        rst = 1'b1; shift = 1'b0; din = '0; address = '0;
        last_din = '0;

        // Power-on reset
        tick();
        rd("por_a0", 6'd0, 16'h0000);
        rd("por_a63", 6'd63, 16'h0000);
        rst = 1'b0;

        // Random prior contents, then a 20 ns mid-cycle reset with shift still high
        shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 16'($urandom_range(1, 16'hFFFF));
            last_din = din;
            tick();
        end
        rd("prefill_a0", 6'd0, last_din);
        #2;
        rst = 1'b1;
        rd("rst_a0", 6'd0, 16'h0000);
        rd("rst_a2", 6'd2, 16'h0000);
        rd("rst_a63", 6'd63, 16'h0000);
        #17;
        shift = 1'b0;
        rst = 1'b0;
        tick();
        rd("post_rst_a2", 6'd2, 16'h0000);

        // Single shift
        din = 16'h0001; shift = 1'b1; address = 6'd0;
        tick();
        shift = 1'b0;
        check("single_a0", 16'h0001);
        rd("single_a1", 6'd1, 16'h0000);

        // Continuous shift: 1,1,FFFF,00FF,00FF watched at tap 2
        address = 6'd2;
        shift = 1'b1;
        din = 16'h0001; tick(); check("cont_e1_a2", 16'h0000);
        din = 16'h0001; tick(); check("cont_e2_a2", 16'h0001);
        din = 16'hFFFF; tick(); check("cont_e3_a2", 16'h0001);
        rd("cont_e3_a0", 6'd0, 16'hFFFF);
        address = 6'd2;
        din = 16'h00FF; tick(); check("cont_e4_a2", 16'h0001);
        rd("cont_e4_a0", 6'd0, 16'h00FF);
        address = 6'd2;
        tick(); check("cont_e5_a2", 16'hFFFF);
        shift = 1'b0;

        // Hold: load 1..4, then ignore din (random or X) for 10 cycles
        shift = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 16'(i);
            tick();
        end
        shift = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = (i % 3 == 0) ? 'x : 16'($urandom);
            tick();
        end
        din = '0;
        rd("hold_a0", 6'd0, 16'd4);
        rd("hold_a1", 6'd1, 16'd3);
        rd("hold_a2", 6'd2, 16'd2);
        rd("hold_a3", 6'd3, 16'd1);

        // Depth/overflow: 65 words 0..64, word 0 falls off the end
        shift = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            din = 16'(i);
            tick();
        end
        shift = 1'b0;
        rd("ovf_a63", 6'd63, 16'd1);
        rd("ovf_a62", 6'd62, 16'd2);
        rd("ovf_a1", 6'd1, 16'd63);
        rd("ovf_a0", 6'd0, 16'd64);
        rd("ovf_a31", 6'd31, 16'd33);

        // Reset between edges while shifting; resume from all-zero
        shift = 1'b1;
        din = 16'h5555;
        tick();
        rd("rs_pre_a0", 6'd0, 16'h5555);
        #1;
        rst = 1'b1;
        rd("rs_async_a0", 6'd0, 16'h0000);
        rd("rs_async_a40", 6'd40, 16'h0000);
        rst = 1'b0;
        din = 16'h1234;
        tick();
        rd("rs_resume1_a0", 6'd0, 16'h1234);
        rd("rs_resume1_a1", 6'd1, 16'h0000);
        din = 16'hABCD;
        tick();
        shift = 1'b0;
        rd("rs_resume2_a0", 6'd0, 16'hABCD);
        rd("rs_resume2_a1", 6'd1, 16'h1234);
        rd("rs_resume2_a2", 6'd2, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_reg
